// File: rtl/glb_pe_pkg.sv
`default_nettype none
// ============================================================================
// Package : glb_pe_pkg
// Brief   : Shared PE-array geometry, scheduler state encoding and tag record.
// Rev     : 1.0 - initial release
// ============================================================================
package glb_pe_pkg;

    // Array geometry is fixed here because the tag record and the strobe
    // vector widths of every file in this slice derive from it.
    localparam int NUM_ROW   = 4;
    localparam int NUM_COL   = 4;
    localparam int NUM_PE    = NUM_ROW * NUM_COL;
    localparam int TAG_WIDTH = 4;
    localparam int IDX_WIDTH = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TAG_DRIVE = 3'd1,
        RUN       = 3'd2,
        DONE      = 3'd3,
        ERROR     = 3'd4
    } sched_state_t;

    typedef struct packed {
        logic [TAG_WIDTH-1:0] row_tag;
        logic [TAG_WIDTH-1:0] col_tag;
    } pe_tag_t;

endpackage
`default_nettype wire

// File: rtl/glb_pe_cfg_sched_if.sv
`default_nettype none
// ============================================================================
// Interface : glb_pe_cfg_sched_if
// Brief     : Input beat stream plus PE-array multicast bus and tag strobes.
// Rev       : 1.0 - initial release
// ============================================================================
interface glb_pe_cfg_sched_if #(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 4,
    parameter int NUM_PE     = 16
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic [TAG_WIDTH-1:0]  s_row_tag;
    logic [TAG_WIDTH-1:0]  s_col_tag;

    logic [NUM_PE-1:0]     pe_external;
    logic [NUM_PE-1:0]     pe_tag_lock;

    logic                  bus_valid;
    logic                  bus_ready;
    logic [DATA_WIDTH-1:0] bus_data;
    logic [TAG_WIDTH-1:0]  bus_row_tag;
    logic [TAG_WIDTH-1:0]  bus_col_tag;

    modport master (
        input  s_valid, s_data, s_row_tag, s_col_tag, pe_tag_lock, bus_ready,
        output s_ready, pe_external, bus_valid, bus_data, bus_row_tag, bus_col_tag
    );

    modport slave (
        output s_valid, s_data, s_row_tag, s_col_tag, pe_tag_lock, bus_ready,
        input  s_ready, pe_external, bus_valid, bus_data, bus_row_tag, bus_col_tag
    );
endinterface
`default_nettype wire

// File: rtl/glb_pe_tag_table.sv
`default_nettype none
// ============================================================================
// Module : glb_pe_tag_table
// Brief  : NUM_PE-entry (row,col) tag register file, sync write, comb read.
// Rev    : 1.0 - initial release
// ============================================================================
module glb_pe_tag_table
    import glb_pe_pkg::*;
(
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [IDX_WIDTH-1:0] wr_addr,
    input  pe_tag_t              wr_data,
    input  logic [IDX_WIDTH-1:0] rd_addr,
    output pe_tag_t              rd_data
);
    // Contents are deliberately left out of reset so a table survives rstn.
    pe_tag_t r_mem [NUM_PE];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];
endmodule
`default_nettype wire

// File: rtl/glb_pe_cfg_sched.sv
`default_nettype none
// ============================================================================
// Module : glb_pe_cfg_sched
// Brief  : Tags each global PE in turn, then forwards tagged beats to the bus.
// Rev    : 1.0 - initial release
// ============================================================================
module glb_pe_cfg_sched
    import glb_pe_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 255,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 tbl_we,
    input  logic [IDX_WIDTH-1:0] tbl_addr,
    input  logic [TAG_WIDTH-1:0] tbl_row_tag,
    input  logic [TAG_WIDTH-1:0] tbl_col_tag,
    input  logic                 start,
    input  logic                 abort,
    input  logic [LEN_WIDTH-1:0] run_len,
    glb_pe_cfg_sched_if.master   sif,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);
    localparam int WAIT_WIDTH = $clog2(TIMEOUT + 1);

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;
    logic [IDX_WIDTH-1:0]  r_pe_idx;
    logic [WAIT_WIDTH-1:0] r_wait_cnt;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_beat_cnt;
    logic [LEN_WIDTH-1:0]  r_acc_cnt;
    logic                  r_skid_valid;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic [TAG_WIDTH-1:0]  r_skid_row;
    logic [TAG_WIDTH-1:0]  r_skid_col;

    pe_tag_t w_cur_tag;
    logic    w_lock;
    logic    w_timeout;
    logic    w_last_pe;
    logic    w_s_ready;
    logic    w_accept;
    logic    w_handshake;
    logic    w_last_beat;
    logic    w_restart;

    glb_pe_tag_table u_tag_table (
        .clk     (clk),
        .wr_en   (tbl_we && (r_state == IDLE)),
        .wr_addr (tbl_addr),
        .wr_data ({tbl_row_tag, tbl_col_tag}),
        .rd_addr (r_pe_idx),
        .rd_data (w_cur_tag)
    );

    assign w_lock      = sif.pe_tag_lock[r_pe_idx];
    assign w_timeout   = (r_wait_cnt == WAIT_WIDTH'(TIMEOUT));
    assign w_last_pe   = (r_pe_idx == IDX_WIDTH'(NUM_PE - 1));
    assign w_restart   = ((r_state == IDLE) || (r_state == ERROR)) && start && !abort;
    // Acceptance stops once len beats are in, so beat_cnt can never pass len.
    assign w_s_ready   = (r_state == RUN) && (r_acc_cnt != r_len) &&
                         (!r_skid_valid || sif.bus_ready);
    assign w_accept    = sif.s_valid && w_s_ready;
    assign w_handshake = (r_state == RUN) && r_skid_valid && sif.bus_ready;
    assign w_last_beat = w_handshake && ((r_beat_cnt + LEN_WIDTH'(1)) == r_len);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE, ERROR: begin
                    if (start) w_state_nxt = TAG_DRIVE;
                end
                TAG_DRIVE: begin
                    if (w_lock) begin
                        if (w_last_pe) w_state_nxt = (r_len == '0) ? DONE : RUN;
                    end else if (w_timeout) begin
                        w_state_nxt = ERROR;
                    end
                end
                RUN: begin
                    if (w_last_beat) w_state_nxt = DONE;
                end
                DONE:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pe_idx     <= '0;
            r_wait_cnt   <= '0;
            r_len        <= '0;
            r_beat_cnt   <= '0;
            r_acc_cnt    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_row   <= '0;
            r_skid_col   <= '0;
        end else begin
            if (w_restart) begin
                r_pe_idx   <= '0;
                r_wait_cnt <= '0;
                r_len      <= run_len;
                r_beat_cnt <= '0;
                r_acc_cnt  <= '0;
            end else if (r_state == TAG_DRIVE) begin
                if (w_lock) begin
                    r_wait_cnt <= '0;
                    if (!w_last_pe) r_pe_idx <= r_pe_idx + 1'b1;
                end else if (!w_timeout) begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
            end

            if (w_accept)    r_acc_cnt  <= r_acc_cnt + 1'b1;
            if (w_handshake) r_beat_cnt <= r_beat_cnt + 1'b1;

            // Leaving RUN for any reason (abort included) empties the skid.
            if (w_state_nxt != RUN) begin
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= sif.s_data;
                r_skid_row   <= sif.s_row_tag;
                r_skid_col   <= sif.s_col_tag;
            end else if (w_handshake) begin
                r_skid_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        sif.pe_external = '0;
        sif.bus_valid   = 1'b0;
        sif.bus_data    = '0;
        sif.bus_row_tag = '0;
        sif.bus_col_tag = '0;
        done            = 1'b0;
        error           = 1'b0;
        case (r_state)
            TAG_DRIVE: begin
                sif.pe_external = NUM_PE'(1) << r_pe_idx;
                sif.bus_valid   = 1'b1;
                sif.bus_row_tag = w_cur_tag.row_tag;
                sif.bus_col_tag = w_cur_tag.col_tag;
            end
            RUN: begin
                sif.bus_valid   = r_skid_valid;
                sif.bus_data    = r_skid_data;
                sif.bus_row_tag = r_skid_row;
                sif.bus_col_tag = r_skid_col;
            end
            DONE:    done  = 1'b1;
            ERROR:   error = 1'b1;
            default: ;
        endcase
    end

    assign sif.s_ready = w_s_ready;
    assign busy        = (r_state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_glb_pe_cfg_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_glb_pe_cfg_sched
// Brief  : Directed/random bench for glb_pe_cfg_sched with a queue-based model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_glb_pe_cfg_sched;
    import glb_pe_pkg::*;

    localparam int DATA_WIDTH = 16;
    localparam int LEN_WIDTH  = 16;
    localparam int TIMEOUT    = 255;
    localparam int BEAT_W     = DATA_WIDTH + 2 * TAG_WIDTH;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 tbl_we;
    logic [IDX_WIDTH-1:0] tbl_addr;
    logic [TAG_WIDTH-1:0] tbl_row_tag;
    logic [TAG_WIDTH-1:0] tbl_col_tag;
    logic                 start;
    logic                 abort;
    logic [LEN_WIDTH-1:0] run_len;
    logic                 busy;
    logic                 done;
    logic                 error;

    int checks = 0;
    int errors = 0;

    logic [TAG_WIDTH-1:0] exp_row [NUM_PE];
    logic [TAG_WIDTH-1:0] exp_col [NUM_PE];

    glb_pe_cfg_sched_if #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH),
        .NUM_PE     (NUM_PE)
    ) sif ();

    glb_pe_cfg_sched #(
        .DATA_WIDTH (DATA_WIDTH),
        .TIMEOUT    (TIMEOUT),
        .LEN_WIDTH  (LEN_WIDTH)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .tbl_we      (tbl_we),
        .tbl_addr    (tbl_addr),
        .tbl_row_tag (tbl_row_tag),
        .tbl_col_tag (tbl_col_tag),
        .start       (start),
        .abort       (abort),
        .run_len     (run_len),
        .sif         (sif),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_table();
        bit [(1<<(2*TAG_WIDTH))-1:0] used;
        logic [2*TAG_WIDTH-1:0]      v;
        used = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            do v = (2*TAG_WIDTH)'($urandom); while (used[v]);
            used[v]     = 1'b1;
            exp_row[k]  = v[2*TAG_WIDTH-1:TAG_WIDTH];
            exp_col[k]  = v[TAG_WIDTH-1:0];
            tbl_we      = 1'b1;
            tbl_addr    = IDX_WIDTH'(k);
            tbl_row_tag = exp_row[k];
            tbl_col_tag = exp_col[k];
            tick();
        end
        tbl_we = 1'b0;
    endtask

    task automatic do_start(input int len);
        run_len = LEN_WIDTH'(len);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // PE-array model: the selected PE raises its lock 'delay' cycles after its
    // strobe appears (random 0..4 when delay<0); others may chatter randomly.
    task automatic tag_phase(input int delay, input int dead_pe, output bit timed_out);
        int d;
        int held;
        bit lk;
        timed_out = 1'b0;
        for (int k = 0; k < NUM_PE; k++) begin
            d    = (delay < 0) ? int'($urandom_range(0, 4)) : delay;
            held = 0;
            while (1) begin
                lk = (k != dead_pe) && (held >= d);
                sif.pe_tag_lock = lk ? (NUM_PE'(1) << k)
                                     : (NUM_PE'($urandom) & ~(NUM_PE'(1) << k));
                tbl_we      = (k == 3) && (held == 0);
                tbl_addr    = IDX_WIDTH'(NUM_PE - 1);
                tbl_row_tag = ~exp_row[NUM_PE-1];
                tbl_col_tag = ~exp_col[NUM_PE-1];
                #1;
                chk("strobe", 64'(sif.pe_external), 64'(NUM_PE'(1) << k));
                chk("tag_valid", 64'(sif.bus_valid), 64'd1);
                chk("tag_data", 64'(sif.bus_data), 64'd0);
                chk("tag_value", 64'({sif.bus_row_tag, sif.bus_col_tag}),
                    64'({exp_row[k], exp_col[k]}));
                tick();
                if (lk) break;
                if (held == TIMEOUT) begin
                    timed_out       = 1'b1;
                    tbl_we          = 1'b0;
                    sif.pe_tag_lock = '0;
                    return;
                end
                held++;
            end
        end
        tbl_we          = 1'b0;
        sif.pe_tag_lock = '0;
    endtask

    // Stream model: accepted beats queue up and must appear on the bus in order,
    // one register stage later, holding while the bus stalls.
    task automatic run_phase(input int len, input int rdy_pct, input int val_pct, output int cyc);
        logic [BEAT_W-1:0] q[$];
        logic [BEAT_W-1:0] beat;
        int  acc;
        int  got;
        bit  exp_sr;
        acc = 0;
        got = 0;
        cyc = 0;
        while (got < len && cyc < 2000) begin
            sif.bus_ready = ($urandom_range(0, 99) < rdy_pct);
            sif.s_valid   = ($urandom_range(0, 99) < val_pct);
            beat          = BEAT_W'($urandom);
            {sif.s_data, sif.s_row_tag, sif.s_col_tag} = beat;
            #1;
            exp_sr = (acc < len) && ((q.size() == 0) || sif.bus_ready);
            chk("run_valid", 64'(sif.bus_valid), 64'(q.size() != 0));
            if (q.size() != 0)
                chk("run_beat", 64'({sif.bus_data, sif.bus_row_tag, sif.bus_col_tag}), 64'(q[0]));
            chk("run_s_ready", 64'(sif.s_ready), 64'(exp_sr));
            chk("run_no_done", 64'(done), 64'd0);
            if ((q.size() != 0) && sif.bus_ready) begin
                void'(q.pop_front());
                got++;
            end
            if (sif.s_valid && exp_sr) begin
                q.push_back(beat);
                acc++;
            end
            tick();
            cyc++;
        end
        sif.s_valid = 1'b0;
        chk("run_count", 64'(got), 64'(len));
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_bus_idle", 64'(sif.bus_valid), 64'd0);
        tick();
        chk("done_single", 64'(done), 64'd0);
        chk("idle_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        bit to;
        int cyc;
        rstn            = 1'b1;
        tbl_we          = 1'b0;
        tbl_addr        = '0;
        tbl_row_tag     = '0;
        tbl_col_tag     = '0;
        start           = 1'b0;
        abort           = 1'b0;
        run_len         = '0;
        sif.s_valid     = 1'b0;
        sif.s_data      = '0;
        sif.s_row_tag   = '0;
        sif.s_col_tag   = '0;
        sif.pe_tag_lock = '0;
        sif.bus_ready   = 1'b0;
        #1 rstn = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_bus_valid", 64'(sif.bus_valid), 64'd0);
        chk("rst_strobe", 64'(sif.pe_external), 64'd0);
        tick();
        rstn = 1'b1;
        tick();

        // T1: asynchronous reset in the middle of the tag phase
        load_table();
        do_start(8);
        chk("t1_strobe0", 64'(sif.pe_external), 64'd1);
        tick();
        rstn = 1'b0;
        #1;
        chk("t1_strobe", 64'(sif.pe_external), 64'd0);
        chk("t1_bus_valid", 64'(sif.bus_valid), 64'd0);
        chk("t1_bus_data", 64'(sif.bus_data), 64'd0);
        chk("t1_bus_tags", 64'({sif.bus_row_tag, sif.bus_col_tag}), 64'd0);
        chk("t1_s_ready", 64'(sif.s_ready), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_done", 64'(done), 64'd0);
        chk("t1_error", 64'(error), 64'd0);
        tick();
        rstn = 1'b1;
        tick();
        chk("t1_idle", 64'(busy), 64'd0);

        // T2 + T4: full tag phase (lock 3 cycles after strobe), then 8 beats
        do_start(8);
        tag_phase(3, -1, to);
        chk("t2_no_timeout", 64'(to), 64'd0);
        chk("t2_in_run", 64'(busy), 64'd1);
        run_phase(8, 60, 70, cyc);

        // Throughput: always-ready bus, always-valid source
        do_start(6);
        tag_phase(-1, -1, to);
        run_phase(6, 100, 100, cyc);
        chk("throughput_cycles", 64'(cyc), 64'd7);

        // T5: zero-length run
        do_start(0);
        tag_phase(-1, -1, to);
        chk("t5_done", 64'(done), 64'd1);
        chk("t5_bus_valid", 64'(sif.bus_valid), 64'd0);
        chk("t5_s_ready", 64'(sif.s_ready), 64'd0);
        tick();
        chk("t5_done_single", 64'(done), 64'd0);
        chk("t5_idle", 64'(busy), 64'd0);

        // T3: PE 5 never locks
        do_start(4);
        tag_phase(1, 5, to);
        chk("t3_timed_out", 64'(to), 64'd1);
        chk("t3_error", 64'(error), 64'd1);
        chk("t3_strobe", 64'(sif.pe_external), 64'd0);
        chk("t3_bus_valid", 64'(sif.bus_valid), 64'd0);
        chk("t3_busy", 64'(busy), 64'd1);
        tick();
        chk("t3_sticky", 64'(error), 64'd1);
        do_start(4);
        chk("t3_cleared", 64'(error), 64'd0);
        chk("t3_restart_pe0", 64'(sif.pe_external), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t3_abort_idle", 64'(busy), 64'd0);

        // T6: abort with a full skid and a stalled bus, start in the same cycle
        do_start(4);
        tag_phase(0, -1, to);
        sif.bus_ready = 1'b0;
        sif.s_valid   = 1'b1;
        sif.s_data    = 16'hBEEF;
        sif.s_row_tag = 4'h3;
        sif.s_col_tag = 4'h9;
        #1;
        chk("t6_s_ready", 64'(sif.s_ready), 64'd1);
        tick();
        sif.s_valid = 1'b0;
        #1;
        chk("t6_skid_full", 64'(sif.bus_valid), 64'd1);
        chk("t6_skid_beat", 64'({sif.bus_data, sif.bus_row_tag, sif.bus_col_tag}), 64'h0BEEF39);
        chk("t6_stall_ready", 64'(sif.s_ready), 64'd0);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("t6_idle", 64'(busy), 64'd0);
        chk("t6_bus_valid", 64'(sif.bus_valid), 64'd0);
        chk("t6_no_done", 64'(done), 64'd0);
        tick();
        chk("t6_stay_idle", 64'(busy), 64'd0);
        chk("t6_still_no_done", 64'(done), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
